// File: rtl/fanout_pkg.sv
// Shared constants and types for the eager fanout fork.
// Optional lockstep mode is enabled with the FANOUT_LOCKSTEP_EN macro.
package fanout_pkg;

    localparam int FANOUT_NUM_OUT_DEF    = 7;
    localparam int FANOUT_DATA_WIDTH_DEF = 17;

    // Per-branch mask at the default fanout width.
    typedef logic [FANOUT_NUM_OUT_DEF-1:0] fanout_mask_t;

endpackage

// File: rtl/fanout_pend_tracker.sv
// Tracks slot occupancy and the set of branches still owed the current token.
// With FANOUT_LOCKSTEP_EN defined, a lockstep input makes all pending branches
// take together only when every pending branch is ready.
module fanout_pend_tracker
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = FANOUT_NUM_OUT_DEF
) (
`ifdef FANOUT_LOCKSTEP_EN
    input  logic               lockstep,
`endif
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               accept,
    input  logic [NUM_OUT-1:0] act,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic               full,
    output logic               done
);

    logic               full_q, full_d;
    logic [NUM_OUT-1:0] pend_q, pend_d;
    logic [NUM_OUT-1:0] take;
    logic [NUM_OUT-1:0] pend_n;

    // Valid comes only from registered state, never from out_ready.
    assign out_valid = {NUM_OUT{full_q}} & pend_q;

    // Branch handshakes: eager per-branch, or all-at-once in lockstep mode.
    always_comb begin
        take = out_valid & out_ready;
`ifdef FANOUT_LOCKSTEP_EN
        if (lockstep) begin
            take = out_valid & {NUM_OUT{full_q & (&(out_ready | ~pend_q))}};
        end
`endif
    end

    assign pend_n = pend_q & ~take;
    assign done   = full_q & (pend_n == '0);
    assign full   = full_q;

    // Next-state: flush wins, then load/drop of a new token, then retire.
    always_comb begin
        full_d = full_q;
        pend_d = pend_n;
        if (flush) begin
            full_d = 1'b0;
            pend_d = '0;
        end else if (accept) begin
            // A token with no active branch is consumed without occupying the slot.
            full_d = |act;
            pend_d = act;
        end else if (done) begin
            full_d = 1'b0;
            pend_d = '0;
        end
    end

    // Occupancy and pending-branch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            pend_q <= '0;
        end else begin
            full_q <= full_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/eager_fanout_fork.sv
// One-entry broadcast slot feeding NUM_OUT consumers that take independently.
// Optional macro FANOUT_LOCKSTEP_EN adds cfg_lockstep for legacy all-ready takes.
module eager_fanout_fork
    import fanout_pkg::*;
#(
    parameter int NUM_OUT    = FANOUT_NUM_OUT_DEF,
    parameter int DATA_WIDTH = FANOUT_DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_OUT-1:0]    cfg_en,
    input  logic [NUM_OUT-1:0]    cfg_sel,
`ifdef FANOUT_LOCKSTEP_EN
    input  logic                  cfg_lockstep,
`endif
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic                  busy
);

    logic [NUM_OUT-1:0]    act;
    logic                  full;
    logic                  done;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // Active set is sampled only when a token is accepted.
    assign act = cfg_en & cfg_sel;

    // The slot refills in the same cycle the last branch takes the old token.
    assign in_ready = ~flush & (~full | done);
    assign accept   = in_valid & in_ready;
    assign busy     = full;
    assign out_data = data_q;

    fanout_pend_tracker #(
        .NUM_OUT (NUM_OUT)
    ) u_tracker (
`ifdef FANOUT_LOCKSTEP_EN
        .lockstep  (cfg_lockstep),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .accept    (accept),
        .act       (act),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .full      (full),
        .done      (done)
    );

    // Capture only tokens that have at least one destination.
    always_comb begin
        data_d = data_q;
        if (accept && (act != '0)) begin
            data_d = in_data;
        end
    end

    // Broadcast data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule
